// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: IDLE -> ISSUE -> WAIT -> RESP handshake against a stalling memory.
// Optional `LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses before any strobe.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] addr,
   output logic [31:0] write_data,
   output logic        memread,
   output logic        memwrite,
   output logic [3:0]  sign_mask,
   input  logic [31:0] read_data,
   input  logic        clk_stall,
   output logic [1:0]  dbg_state
);

   // Handshake: a request moves when req_valid & req_ready at a rising edge;
   // rsp_valid is a single-cycle pulse with no backpressure.
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    mask_q, mask_d;
   logic          we_q, we_d;
   logic          seen_q, seen_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [3:0]    mask_dec;
   logic          legal;
   logic          misalign;
   logic          accept;
   logic [31:0]   shifted;
   logic [31:0]   ext;

   always_comb begin
      mask_dec = 4'b0000;
      legal    = 1'b0;
      if (req_we) begin
         case (req_funct3)
            3'b000:  begin mask_dec = 4'b0001; legal = 1'b1; end
            3'b001:  begin mask_dec = 4'b0011; legal = 1'b1; end
            3'b010:  begin mask_dec = 4'b0111; legal = 1'b1; end
            default: begin mask_dec = 4'b0000; legal = 1'b0; end
         endcase
      end else begin
         case (req_funct3)
            3'b000:  begin mask_dec = 4'b1001; legal = 1'b1; end
            3'b001:  begin mask_dec = 4'b1011; legal = 1'b1; end
            3'b010:  begin mask_dec = 4'b0111; legal = 1'b1; end
            3'b100:  begin mask_dec = 4'b0001; legal = 1'b1; end
            3'b101:  begin mask_dec = 4'b0011; legal = 1'b1; end
            default: begin mask_dec = 4'b0000; legal = 1'b0; end
         endcase
      end
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = (mask_dec[2] && (req_addr[1:0] != 2'b00)) ||
                 (!mask_dec[2] && mask_dec[1] && req_addr[0]);
`else
      misalign = 1'b0;
`endif
   end

   assign req_ready = (state_q == IDLE) && !clk_stall;
   assign accept    = req_valid && req_ready;

   // The memory returns the whole word; pick the addressed lane and extend it.
   always_comb begin
      shifted = read_data >> {addr_q[1:0], 3'b000};
      if (mask_q[2]) begin
         ext = shifted;
      end else if (mask_q[1]) begin
         ext = {{16{mask_q[3] & shifted[15]}}, shifted[15:0]};
      end else begin
         ext = {{24{mask_q[3] & shifted[7]}}, shifted[7:0]};
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      we_d    = we_q;
      seen_d  = seen_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rdata_d = 32'h0;
               err_d   = 1'b0;
               seen_d  = 1'b0;
               cnt_d   = '0;
               if (legal && !misalign) begin
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  mask_d  = mask_dec;
                  we_d    = req_we;
                  state_d = ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (clk_stall) seen_d = 1'b1;
            // Completion wins over timeout when both happen on the same edge.
            if (!clk_stall && seen_q) begin
               rdata_d = we_q ? 32'h0 : ext;
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         mask_q  <= 4'b0000;
         we_q    <= 1'b0;
         seen_q  <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         we_q    <= we_d;
         seen_q  <= seen_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign memread    = (state_q == ISSUE) && !we_q;
   assign memwrite   = (state_q == ISSUE) && we_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_rdata  = rdata_q;
   assign rsp_err    = err_q;
   assign addr       = addr_q;
   assign write_data = wdata_q;
   assign sign_mask  = mask_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: the maximum number of WAIT cycles before an access is abandoned.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 Port req_valid, input, 1 bit: the pipeline presents an access.
REQ-005 Port req_ready, output, 1 bit: the block accepts an access this cycle.
REQ-006 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 Port req_funct3, input, 3 bits: the RV32I load/store funct3 field.
REQ-008 Ports req_addr and req_wdata, input, 32 bits each: the byte address and the store data.
REQ-009 Port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-010 Port rsp_rdata, output, 32 bits: the extended load data; 0 for stores and errors.
REQ-011 Port rsp_err, output, 1 bit: the access failed (illegal funct3, misaligned, or timeout); valid with rsp_valid.
REQ-012 Memory-side outputs: addr (32 bits), write_data (32 bits), memread (1 bit), memwrite (1 bit), sign_mask (4 bits).
REQ-013 Memory-side inputs: read_data (32 bits) and clk_stall (1 bit, high while the memory is busy).

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with clk_stall = 0; acceptance is req_valid & req_ready at a clock edge.
REQ-022 On acceptance of a legal request, the FSM SHALL register addr, write_data and sign_mask and go to ISSUE.
REQ-023 On acceptance of an illegal request, the FSM SHALL go straight to RESP with rsp_err = 1 and never assert memread or memwrite.
  - Illegal loads: funct3 011, 110 or 111.
  - Illegal stores: funct3 other than 000, 001 or 010.
REQ-024 sign_mask encoding:
  - LB 1001, LBU 0001.
  - LH 1011, LHU 0011.
  - LW 0111.
  - SB 0001, SH 0011, SW 0111.
REQ-025 ISSUE SHALL last exactly one cycle, with memread = ~we and memwrite = we; the next state is WAIT with both strobes at 0.
REQ-026 WAIT SHALL set a seen flag when clk_stall = 1.
REQ-027 WAIT SHALL complete when clk_stall = 0 with seen set; on that edge it SHALL capture read_data into rsp_rdata (loads only) and go to RESP.
REQ-028 The WAIT counter SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES it SHALL force RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-029 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE; there is no response backpressure.
REQ-030 Against a memory that raises clk_stall one edge after the strobe and drops it two edges later, rsp_valid SHALL be high in the 4th cycle after the acceptance edge, for both loads and stores.
REQ-031 addr, write_data and sign_mask SHALL hold stable from ISSUE until RESP.
REQ-032 memread and memwrite SHALL never be high at the same time and SHALL never be high outside ISSUE.
REQ-033 Back-to-back requests: a request arriving during RESP SHALL be accepted in the following IDLE cycle at the earliest.

Reset
REQ-040 With rst = 1 at an edge, the block SHALL go to IDLE and clear the seen flag and the counter.
REQ-041 Reset values: memread, memwrite, rsp_valid and rsp_err are 0; addr, write_data, rsp_rdata and sign_mask are 0.
REQ-042 Reset mid-access SHALL abandon the access with no rsp_valid; req_ready then stays 0 until clk_stall = 0.

Configuration
REQ-050 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL be treated as illegal (REQ-023): RESP with rsp_err = 1 and no memory strobe.
  - Halfword misaligned: addr[0] = 1.
  - Word misaligned: addr[1:0] != 00.
REQ-051 Without LSU_MISALIGN_TRAP_EN, a misaligned address SHALL be forwarded unchanged and the memory decides the result.

Verification
REQ-060 LH at 0x0000_0102 with the memory word 0x80F1_1234 -> rsp_valid in cycle 4, rsp_rdata = 0xFFFF_80F1, rsp_err = 0, sign_mask = 1011.
REQ-061 SB at 0x0000_0003 with req_wdata = 0x0000_00AB -> one memwrite cycle, write_data = 0x0000_00AB, sign_mask = 0001, rsp_valid = 1, rsp_rdata = 0.
REQ-062 Load with funct3 = 111 -> rsp_valid with rsp_err = 1 on the 2nd edge after acceptance, and memread is never asserted.
REQ-063 clk_stall held at 0 after ISSUE with TIMEOUT_CYCLES = 16 -> rsp_err = 1 and rsp_rdata = 0 exactly 16 cycles after entering WAIT.
REQ-064 rst asserted while clk_stall = 1 -> no rsp_valid, req_ready = 0 until clk_stall falls, then the next LW completes normally.
REQ-065 LSU_MISALIGN_TRAP_EN defined, LW at 0x0000_0006 -> rsp_err = 1 with no strobe; macro undefined -> memread pulse with addr = 0x0000_0006.
